// File: rtl/urna_multicand_pkg.sv
// Shared types and constants for the multi-candidate ballot box.
package urna_multicand_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEntry  = 2'd1,
        StDone   = 2'd2,
        StClosed = 2'd3
    } state_e;

    localparam int unsigned BcdMax = 9;

    // Bit width of an n-digit packed BCD code.
    function automatic int unsigned code_w(input int unsigned n);
        return n * 4;
    endfunction

endpackage

// File: rtl/urna_digit_capture.sv
// Valid falling-edge detector feeding a BCD shift buffer with digit count and sticky bad flag.
module urna_digit_capture
    import urna_multicand_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned CNT_DW   = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [3:0]              digit_i,
    input  logic                    valid_i,
    input  logic                    clear_i,
    input  logic                    shift_i,
    output logic                    accept_o,
    output logic [N_DIGITS*4-1:0]   code_o,
    output logic [CNT_DW-1:0]       count_o,
    output logic                    bad_o
);

    localparam int unsigned CodeW = code_w(N_DIGITS);

    logic                valid_q;
    logic [CodeW-1:0]    code_q, code_d, shift_code;
    logic [CNT_DW-1:0]   count_q, count_d;
    logic                bad_q, bad_d;

    assign accept_o = valid_q & ~valid_i;

    // Newest digit enters the LS nibble so the first digit ends up in the MS nibble.
    if (N_DIGITS == 1) begin : g_one
        assign shift_code = digit_i;
    end else begin : g_multi
        assign shift_code = {code_q[CodeW-5:0], digit_i};
    end

    always_comb begin
        code_d  = code_q;
        count_d = count_q;
        bad_d   = bad_q;
        if (clear_i) begin
            code_d  = '0;
            count_d = '0;
            bad_d   = 1'b0;
        end else if (shift_i) begin
            code_d  = shift_code;
            count_d = count_q + CNT_DW'(1);
            if (digit_i > 4'(BcdMax)) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            valid_q <= valid_i;
            code_q  <= code_d;
            count_q <= count_d;
            bad_q   <= bad_d;
        end
    end

    assign code_o  = code_q;
    assign count_o = count_q;
    assign bad_o   = bad_q;

endmodule

// File: rtl/urna_multicand.sv
// Parametrised ballot box: session FSM, candidate code match and saturating tallies.
module urna_multicand
    import urna_multicand_pkg::*;
#(
    parameter int unsigned N_CAND   = 4,
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned CNT_W    = 8,
    parameter logic [N_CAND*N_DIGITS*4-1:0] CAND_CODES = 64'h3494_3485_3472_3504
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [3:0]                Digit,
    input  logic                      Valid,
    input  logic                      Next,
    input  logic                      Correct,
    input  logic                      Blank,
    input  logic                      Finish,
    output logic [N_CAND*CNT_W-1:0]   Votes,
    output logic [CNT_W-1:0]          Nulo,
    output logic [CNT_W-1:0]          Branco,
    output logic [CNT_W+3:0]          Total,
    output logic                      StatusValido,
    output logic                      StatusNulo,
    output logic                      Closed
);

    localparam int unsigned CodeW = code_w(N_DIGITS);
    localparam int unsigned CntDw = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    state_e            state_q, state_d;
    logic              clear, shift, accept, bad, blank_vote;
    logic              commit_q, commit_d;
    logic [CodeW-1:0]  code;
    logic [CntDw-1:0]  count;
    logic              first_digit, last_digit;

    urna_digit_capture #(
        .N_DIGITS (N_DIGITS),
        .CNT_DW   (CntDw)
    ) u_capture (
        .Clock    (Clock),
        .Reset    (Reset),
        .digit_i  (Digit),
        .valid_i  (Valid),
        .clear_i  (clear),
        .shift_i  (shift),
        .accept_o (accept),
        .code_o   (code),
        .count_o  (count),
        .bad_o    (bad)
    );

    assign first_digit = (count == '0);
    assign last_digit  = (count == CntDw'(N_DIGITS - 1));

    always_comb begin
        state_d    = state_q;
        clear      = 1'b0;
        shift      = 1'b0;
        blank_vote = 1'b0;
        commit_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Finish) begin
                    state_d = StClosed;
                end else if (Next) begin
                    state_d = StEntry;
                    clear   = 1'b1;
                end
            end
            StEntry: begin
                if (Finish) begin
                    state_d = StClosed;
                end else if (Next || Correct) begin
                    clear = 1'b1;
                end else if (Blank && first_digit) begin
                    blank_vote = 1'b1;
                    state_d    = StDone;
                end else if (accept) begin
                    shift = 1'b1;
                    if (last_digit) begin
                        commit_d = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (Finish) begin
                    state_d = StClosed;
                end else if (Next) begin
                    state_d = StEntry;
                    clear   = 1'b1;
                end
            end
            StClosed: begin
                state_d = StClosed;
            end
            default: state_d = StIdle;
        endcase
    end

    // One comparator per candidate; candidate 0 sits in the MS slice of CAND_CODES.
    logic [N_CAND-1:0] match;
    for (genvar i = 0; i < N_CAND; i++) begin : g_cmp
        assign match[i] = (code == CAND_CODES[(N_CAND-1-i)*CodeW +: CodeW]);
    end

    logic [N_CAND-1:0] win;
    logic              found;
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_CAND; i++) begin
            win[i] = match[i] & ~found;
            found  = found | match[i];
        end
    end

    logic valid_vote;
    assign valid_vote = found & ~bad;

    logic [CNT_W-1:0] votes_q [N_CAND];
    logic [CNT_W-1:0] votes_d [N_CAND];
    logic [CNT_W-1:0] nulo_q, nulo_d, branco_q, branco_d;
    logic [CNT_W+3:0] total_q, total_d;
    logic             valido_q, valido_d, stnulo_q, stnulo_d;

    always_comb begin
        for (int i = 0; i < N_CAND; i++) begin
            votes_d[i] = votes_q[i];
            if (commit_q && valid_vote && win[i] && (votes_q[i] != '1)) begin
                votes_d[i] = votes_q[i] + CNT_W'(1);
            end
        end
        nulo_d   = nulo_q;
        branco_d = branco_q;
        total_d  = total_q;
        if (commit_q && !valid_vote && (nulo_q != '1)) begin
            nulo_d = nulo_q + CNT_W'(1);
        end
        if (blank_vote && (branco_q != '1)) begin
            branco_d = branco_q + CNT_W'(1);
        end
        if ((commit_q || blank_vote) && (total_q != '1)) begin
            total_d = total_q + (CNT_W+4)'(1);
        end
    end

    // Status reflects the last vote only while the session sits in DONE.
    always_comb begin
        valido_d = valido_q;
        stnulo_d = stnulo_q;
        if (state_d != StDone) begin
            valido_d = 1'b0;
            stnulo_d = 1'b0;
        end else if (commit_q) begin
            valido_d = valid_vote;
            stnulo_d = ~valid_vote;
        end else if (blank_vote) begin
            valido_d = 1'b0;
            stnulo_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            commit_q <= 1'b0;
            for (int i = 0; i < N_CAND; i++) begin
                votes_q[i] <= '0;
            end
            nulo_q   <= '0;
            branco_q <= '0;
            total_q  <= '0;
            valido_q <= 1'b0;
            stnulo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            commit_q <= commit_d;
            for (int i = 0; i < N_CAND; i++) begin
                votes_q[i] <= votes_d[i];
            end
            nulo_q   <= nulo_d;
            branco_q <= branco_d;
            total_q  <= total_d;
            valido_q <= valido_d;
            stnulo_q <= stnulo_d;
        end
    end

    for (genvar i = 0; i < N_CAND; i++) begin : g_votes
        assign Votes[i*CNT_W +: CNT_W] = votes_q[i];
    end

    assign Nulo         = nulo_q;
    assign Branco       = branco_q;
    assign Total        = total_q;
    assign StatusValido = valido_q;
    assign StatusNulo   = stnulo_q;
    assign Closed       = (state_q == StClosed);

endmodule
